ps2_kb_rx_fifo: RTL
===================

Name: ps2_kb_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver, successor to the single-register scan-code decoder. It filters and synchronises ps2_clk/ps2_data and captures 11-bit frames with start, stop, optional parity checks and a mid-frame timeout. Decoded {expand, break, code} words are queued in a FIFO drained by a valid/ready handshake, so the CPU-side bus polls keys without losing bursts.

Parameters:
FILT_LEN, 8, consecutive identical synchronised ps2_clk samples required before the filtered level changes (>=2).
TIMEOUT_CYC, 100000, clk cycles without a filtered falling edge, while mid-frame, before the frame is aborted.
FIFO_DEPTH, 8, FIFO entries; power of 2, >=2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
key_data  out  10  FIFO head: {expand, break, scan_code[7:0]}
key_valid  out  1  FIFO non-empty
key_ready  in  1  consumer pop; a pop occurs when key_valid & key_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count
overflow  out  1  sticky: a key word was dropped because the FIFO was full
ovf_clr  in  1  clears overflow; a new drop in the same cycle wins and overflow stays 1
frame_err  out  1  one-cycle pulse on a bad start, stop or parity bit, or on timeout

Behaviour:
- Reset: all outputs 0, key_data 0, FIFO empty, FSM IDLE, expand/break flags 0, filtered clock level 1.
- Sync: 2-FF synchronisers on ps2_clk and ps2_data. Filter counter: the filtered level toggles only after FILT_LEN consecutive samples differ from it.
- fall = filtered level goes 1 to 0. On the fall cycle, sample synchronised data into frame[bit_cnt], LSB first.
- FSM states:
  - IDLE: on fall, capture bit0 (start), set bit_cnt=1, go to RECV.
  - RECV: capture on each fall and increment bit_cnt. After bit 10 (stop) is captured, go to CHECK. If the idle counter reaches TIMEOUT_CYC, pulse frame_err, set bit_cnt=0, clear both flags, go to IDLE.
  - CHECK: lasts 1 cycle, then returns to IDLE.
    - Error case: start!=0, stop!=1 or parity failure. Pulse frame_err, clear both flags, push nothing.
    - Good frame, code 8'hE0: set expand. Code 8'hF0: set break.
    - Any other code: push {expand, break, code} and clear both flags.
- Idle counter resets on every fall and is held at 0 in IDLE.
- Latency: with the stop-bit fall in cycle E, CHECK occurs in E+1 and key_valid/key_data are visible in E+2, provided the FIFO was empty.
- FIFO: first-word-fall-through; key_data is valid whenever key_valid=1.
  - Push while full: word dropped, overflow set.
  - Push and pop in the same cycle while full: both occur, level unchanged, no overflow.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- Reset mid-frame: all state cleared immediately; any partial frame is discarded.

Optional Feature:
PS2_RX_PARITY_EN.
- Defined: frame[9] must make frame[8:1] plus parity odd; a mismatch is a frame error.
- Undefined: frame[9] is ignored; only start/stop checks apply.

Decomposition:
Package ps2_kb_pkg holds:
- localparams PS2_CODE_EXT=8'hE0, PS2_CODE_BRK=8'hF0, PS2_FRAME_BITS=11
- FSM state encoding IDLE/RECV/CHECK
- key word field offsets (EXP=9, BRK=8)

The FIFO is one natural sub-module, ps2_kb_fifo, parametrised by width=10 and FIFO_DEPTH.

Test Plan:
- Send frame 0x1C with correct parity (PS2_RX_PARITY_EN on) -> key_valid rises at E+2, key_data=10'h01C, fifo_level=1.
- Send F0, 1C, then E0, F0, 75 -> queue holds 10'h11C then 10'h375; two pops empty the FIFO.
- Send 0x1C with inverted parity -> frame_err pulses 1 cycle, nothing pushed. With the macro undefined -> 10'h01C pushed.
- key_ready=0, send 9 keys with FIFO_DEPTH=8 -> level=8, overflow=1, head=first key. Pulse ovf_clr -> overflow=0.
- Send 5 bits then stop ps2_clk -> frame_err exactly TIMEOUT_CYC cycles after the last fall. A following full frame 0x1C decodes normally.
- Inject 3-cycle low glitches on ps2_clk (FILT_LEN=8) -> no bit captured; assert rst_n low mid-frame -> all outputs 0 and the next frame decodes cleanly.

Source files
------------

// File: rtl/ps2_kb_pkg.sv
// ps2_kb_pkg: shared constants, FSM encoding and frame-check helper for the
// PS/2 keyboard receiver (ps2_kb_rx_fifo) and its key FIFO (ps2_kb_fifo).
//   PS2_CODE_EXT / PS2_CODE_BRK : prefix codes that set the expand / break flags
//   PS2_FRAME_BITS              : start + 8 data + parity + stop
//   KEY_EXP_BIT / KEY_BRK_BIT   : flag positions inside the 10-bit key word
package ps2_kb_pkg;

    localparam logic [7:0] PS2_CODE_EXT   = 8'hE0;
    localparam logic [7:0] PS2_CODE_BRK   = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    localparam int KEY_WORD_W  = 10;
    localparam int KEY_EXP_BIT = 9;
    localparam int KEY_BRK_BIT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_t;

    // Start must be 0 and stop 1; when chk_parity is set, data bits plus the
    // parity bit must hold an odd number of ones.
    function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] frame,
                                          input logic chk_parity);
        logic start_ok;
        logic stop_ok;
        logic par_ok;
        start_ok = (frame[0] == 1'b0);
        stop_ok  = (frame[10] == 1'b1);
        par_ok   = ((^frame[9:1]) == 1'b1);
        return start_ok & stop_ok & (par_ok | ~chk_parity);
    endfunction

endpackage

// File: rtl/ps2_kb_fifo.sv
// ps2_kb_fifo: first-word-fall-through FIFO for decoded key words.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and word
//   pop                 read request (ignored while empty)
//   ovf_clr             clears the sticky overflow flag (a same-cycle drop wins)
//   rd_data, valid      head word (0 while empty) and non-empty flag
//   level               entry count 0..DEPTH
//   overflow            sticky: a push was dropped because the FIFO was full
module ps2_kb_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     ovf_clr,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             ovf_r;

    logic             empty_s;
    logic             full_s;
    logic             do_pop_s;
    logic             do_push_s;
    logic             drop_s;

    // Handshake decode: a pop frees a slot in the same cycle, so a push while
    // full is accepted when it coincides with a pop.
    always_comb begin
        empty_s   = (level_r == '0);
        full_s    = (level_r == (AW+1)'(DEPTH));
        do_pop_s  = pop & ~empty_s;
        do_push_s = push & (~full_s | do_pop_s);
        drop_s    = push & full_s & ~do_pop_s;
    end

    // Storage array; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, entry count and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign valid    = ~empty_s;
    assign rd_data  = empty_s ? '0 : mem_r[rd_ptr_r];
    assign level    = level_r;
    assign overflow = ovf_r;

endmodule

// File: rtl/ps2_kb_rx_fifo.sv
// ps2_kb_rx_fifo: PS/2 keyboard receiver with a key-word FIFO.
// Synchronises and filters ps2_clk/ps2_data, captures 11-bit frames on the
// filtered falling edge, checks start/stop (and parity when the build macro
// PS2_RX_PARITY_EN is defined), tracks E0/F0 prefixes and queues
// {expand, break, code} words for a valid/ready consumer.
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   ps2_clk, ps2_data    raw asynchronous PS/2 lines
//   key_data, key_valid  FIFO head {expand, break, code} and non-empty flag
//   key_ready            consumer pop request
//   fifo_level           current FIFO entry count
//   overflow, ovf_clr    sticky drop flag and its clear
//   frame_err            one-cycle pulse on a bad frame or a mid-frame timeout
// Build option: PS2_RX_PARITY_EN enables the odd-parity check on frame[9].
module ps2_kb_rx_fifo
    import ps2_kb_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [9:0]                    key_data,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          frame_err
);

    localparam int FCW = $clog2(FILT_LEN);
    localparam int ICW = $clog2(TIMEOUT_CYC);

`ifdef PS2_RX_PARITY_EN
    localparam logic PARITY_CHK = 1'b1;
`else
    localparam logic PARITY_CHK = 1'b0;
`endif

    logic                      clk_meta_r, clk_sync_r;
    logic                      data_meta_r, data_sync_r;
    logic [FCW-1:0]            filt_cnt_r, filt_cnt_s;
    logic                      filt_level_r, filt_level_s;
    logic                      fall_s;

    ps2_state_t                state_r, state_s;
    logic [3:0]                bit_cnt_r, bit_cnt_s;
    logic [PS2_FRAME_BITS-1:0] frame_r, frame_s;
    logic [ICW-1:0]            idle_cnt_r, idle_cnt_s;
    logic                      expand_r, expand_s;
    logic                      brk_r, brk_s;
    logic                      frame_err_r, err_s;
    logic                      push_s;
    logic [KEY_WORD_W-1:0]     push_word_s;
    logic                      frame_ok_s;

    // Two-flop synchronisers; reset to the idle-high bus level so no false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Glitch filter: the level flips on the FILT_LEN-th consecutive differing sample.
    always_comb begin
        filt_cnt_s   = filt_cnt_r;
        filt_level_s = filt_level_r;
        if (clk_sync_r != filt_level_r) begin
            if (filt_cnt_r == FCW'(FILT_LEN - 1)) begin
                filt_level_s = ~filt_level_r;
                filt_cnt_s   = '0;
            end else begin
                filt_cnt_s   = filt_cnt_r + FCW'(1);
            end
        end else begin
            filt_cnt_s = '0;
        end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_r   <= '0;
            filt_level_r <= 1'b1;
        end else begin
            filt_cnt_r   <= filt_cnt_s;
            filt_level_r <= filt_level_s;
        end
    end

    assign fall_s     = filt_level_r & ~filt_level_s;
    assign frame_ok_s = ps2_frame_ok(frame_r, PARITY_CHK);

    // Frame FSM next-state, capture, timeout and decode.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        frame_s     = frame_r;
        idle_cnt_s  = idle_cnt_r;
        expand_s    = expand_r;
        brk_s       = brk_r;
        err_s       = 1'b0;
        push_s      = 1'b0;
        push_word_s = '0;
        push_word_s[KEY_EXP_BIT] = expand_r;
        push_word_s[KEY_BRK_BIT] = brk_r;
        push_word_s[7:0]         = frame_r[8:1];
        case (state_r)
            IDLE: begin
                idle_cnt_s = '0;
                if (fall_s) begin
                    frame_s[0] = data_sync_r;
                    bit_cnt_s  = 4'd1;
                    state_s    = RECV;
                end else begin
                    bit_cnt_s  = 4'd0;
                end
            end
            RECV: begin
                if (fall_s) begin
                    frame_s[bit_cnt_r] = data_sync_r;
                    idle_cnt_s         = '0;
                    if (bit_cnt_r == 4'(PS2_FRAME_BITS - 1)) begin
                        bit_cnt_s = 4'd0;
                        state_s   = CHECK;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                // frame_err is registered, so abort one cycle before the count
                // reaches TIMEOUT_CYC; the pulse then lands TIMEOUT_CYC cycles
                // after the last fall.
                end else if (idle_cnt_r == ICW'(TIMEOUT_CYC - 2)) begin
                    err_s      = 1'b1;
                    bit_cnt_s  = 4'd0;
                    idle_cnt_s = '0;
                    expand_s   = 1'b0;
                    brk_s      = 1'b0;
                    state_s    = IDLE;
                end else begin
                    idle_cnt_s = idle_cnt_r + ICW'(1);
                end
            end
            CHECK: begin
                state_s    = IDLE;
                idle_cnt_s = '0;
                if (!frame_ok_s) begin
                    err_s    = 1'b1;
                    expand_s = 1'b0;
                    brk_s    = 1'b0;
                end else if (frame_r[8:1] == PS2_CODE_EXT) begin
                    expand_s = 1'b1;
                end else if (frame_r[8:1] == PS2_CODE_BRK) begin
                    brk_s    = 1'b1;
                end else begin
                    push_s   = 1'b1;
                    expand_s = 1'b0;
                    brk_s    = 1'b0;
                end
            end
            default: begin
                state_s    = IDLE;
                bit_cnt_s  = 4'd0;
                idle_cnt_s = '0;
                expand_s   = 1'b0;
                brk_s      = 1'b0;
            end
        endcase
    end

    // Frame FSM state and error pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 4'd0;
            frame_r     <= '0;
            idle_cnt_r  <= '0;
            expand_r    <= 1'b0;
            brk_r       <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            frame_r     <= frame_s;
            idle_cnt_r  <= idle_cnt_s;
            expand_r    <= expand_s;
            brk_r       <= brk_s;
            frame_err_r <= err_s;
        end
    end

    assign frame_err = frame_err_r;

    ps2_kb_fifo #(
        .WIDTH (KEY_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_word_s),
        .pop       (key_ready),
        .ovf_clr   (ovf_clr),
        .rd_data   (key_data),
        .valid     (key_valid),
        .level     (fifo_level),
        .overflow  (overflow)
    );

endmodule
